// File: rtl/uart_tx.sv
// uart_tx: pops words from a head-of-queue source and sends them as start/data/stop frames on an idle-high line.
module uart_tx #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 31_250,
   parameter int NUM_BITS  = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BITS-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_pop,
   output logic                tx,
   output logic                busy
);
   localparam int CPB = CLK_FREQ / BAUD_RATE;
   localparam int BW  = $clog2(CPB);
   localparam int IW  = NUM_BITS > 1 ? $clog2(NUM_BITS) : 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t              state, state_n;
   logic [BW-1:0]       baud, baud_n;
   logic [IW-1:0]       idx, idx_n;
   logic                stop_cnt, stop_n;
   logic [NUM_BITS-1:0] sh, sh_n;
   logic                tx_n, busy_n, tc;
   assign tc     = baud == BW'(CPB - 1);
   assign tx_pop = rst_n && state == IDLE && tx_valid;
   // tx is registered, so each branch loads the level of the bit about to start
   always_comb begin
      state_n = state;
      baud_n  = tc ? '0 : baud + BW'(1);
      idx_n   = idx;
      stop_n  = stop_cnt;
      sh_n    = sh;
      tx_n    = tx;
      busy_n  = busy;
      case (state)
         IDLE: begin
            baud_n  = '0;
            state_n = tx_valid ? START : IDLE;
            sh_n    = tx_valid ? tx_data : sh;
            tx_n    = !tx_valid;
            busy_n  = tx_valid;
         end
         START: if (tc) begin
            state_n = DATA;
            idx_n   = '0;
            tx_n    = sh[0];
         end
         DATA: if (tc) begin
            if (idx == IW'(NUM_BITS - 1)) begin
               state_n = STOP;
               stop_n  = 1'b0;
               tx_n    = 1'b1;
            end else begin
               sh_n  = sh >> 1;
               idx_n = idx + IW'(1);
               tx_n  = sh_n[0];
            end
         end
         STOP: if (tc) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               stop_n  = 1'b0;
            end else stop_n = 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud     <= '0;
         idx      <= '0;
         stop_cnt <= 1'b0;
         sh       <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         idx      <= idx_n;
         stop_cnt <= stop_n;
         sh       <= sh_n;
         tx       <= tx_n;
         busy     <= busy_n;
      end
   end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the synth's outbound serial path. It pulls words from an upstream `uart_fifo`-style buffer using a head-of-queue/pop handshake, serializes each word as an asynchronous frame, and drives the idle-high `tx` line. Each frame is one start bit, NUM_BITS data bits LSB first, and STOP_BITS stop bits, with no parity. It is the transmit counterpart of the receive-side buffering already in the design.

## Interface
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 31_250: line bit rate in Hz.
  - CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer division.
  - CLKS_PER_BIT must be ≥ 2.
- NUM_BITS, 8: data bits per frame (1..16).
- STOP_BITS, 1: stop bits per frame (1 or 2).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- tx_data  in  NUM_BITS  word at the head of the source buffer.
- tx_valid  in  1  source holds at least one word (not empty).
- tx_pop  out  1  one-cycle consume strobe to the source; connects to the buffer's pop input.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is in flight (any state except IDLE).

## Operation
- States: IDLE, START, DATA, STOP.
- Counters and registers:
  - baud counter: $clog2(CLKS_PER_BIT) bits.
  - bit index: $clog2(NUM_BITS) bits.
  - stop counter: 1 bit.
  - shift register: NUM_BITS wide.
- IDLE:
  - tx=1, busy=0.
  - tx_pop = tx_valid (combinational), forced 0 while rst_n=0.
  - On an edge with tx_valid=1: load shift register from tx_data, clear baud counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit 0.
  - At each baud-counter terminal count (CLKS_PER_BIT-1): shift right, increment bit index.
  - After bit NUM_BITS-1 completes, go to STOP.
- STOP:
  - tx=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
- tx, busy and the state register are registered outputs. tx_pop is the only combinational output.
- The word is captured at the pop edge. Later changes on tx_data or tx_valid do not affect the frame in flight.
- tx_valid dropping mid-frame has no effect. tx_pop is never asserted outside IDLE.
- Reset, including mid-frame: the next edge forces IDLE, tx=1, busy=0, all counters 0. The partial frame is abandoned and no pop is issued.

## Timing
- Reset values: tx=1, busy=0, tx_pop=0.
- The pop edge is cycle N, the edge on which IDLE and tx_valid=1 coincide.
  - tx_pop is high during the cycle before edge N.
  - From cycle N+1: tx=0 and busy=1.
- Start bit occupies cycles N+1 .. N+CLKS_PER_BIT.
- Data bit k occupies CLKS_PER_BIT cycles starting at N+1+(k+1)×CLKS_PER_BIT.
- Frame length F = (1+NUM_BITS+STOP_BITS)×CLKS_PER_BIT cycles; busy is high for exactly F cycles.
- The transmitter returns to IDLE at N+F+1. The earliest next pop edge is N+F+1.
  - The back-to-back frame period is therefore F+1 cycles.
  - The extra cycle appears on the line as one clk of additional stop level.
- Exactly one tx_pop pulse per frame; each pulse is one cycle wide.

## Test plan
Test parameters: CLK_FREQ=16, BAUD_RATE=4 (CLKS_PER_BIT=4), NUM_BITS=8, STOP_BITS=1, so F=40.
- Reset check: hold rst_n=0 for 5 cycles with tx_valid=1 → tx=1, busy=0, tx_pop=0 throughout; first pop on the first edge after release.
- Single frame: tx_valid=1 for one pop with tx_data=8'hA5, then 0.
  - Line sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - busy high for exactly 40 cycles; one tx_pop pulse.
- Back-to-back: tx_valid held 1 with words 8'h00 then 8'hFF → two pops 41 cycles apart.
  - Frame 1 data all 0; frame 2 data all 1.
  - One extra high cycle between the frames.
- Data stability: change tx_data to 8'h3C and drop tx_valid during DATA of an 8'h81 frame → 8'h81 is transmitted intact and no second pop occurs.
- Reset mid-frame: assert rst_n=0 at the third data bit → tx=1 and busy=0 on the next edge. After release with tx_valid=1, a fresh, complete frame starts with the start bit.
- Two stop bits: rebuild with STOP_BITS=2 and send 8'h55 → stop level lasts 8 cycles; busy high for 44 cycles.
